// File: rtl/pp_constants_pkg.sv
// rtl/pp_constants_pkg.sv - shared command width and sequencer state type for the pp command path
package pp_constants;

  localparam int CMD_SIZE_LOG2 = 5;
  localparam int CMD_W         = 2 ** CMD_SIZE_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } pp_seq_state_t;

endpackage

// File: rtl/pp_cmd_fifo.sv
// rtl/pp_cmd_fifo.sv - synchronous command FIFO with async reset, flush and registered level
module pp_cmd_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flush,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // A write is refused when full, so a same-cycle pop never makes room for it.
  assign push    = wr_en && !full && !flush;
  assign pop     = rd_en && !empty && !flush;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pp_cmd_sequencer.sv
// rtl/pp_cmd_sequencer.sv - buffers host commands and issues them one at a time to the pp core
module pp_cmd_sequencer #(
  parameter  int CMD_SIZE_LOG2  = pp_constants::CMD_SIZE_LOG2,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_W          = 16,
  localparam int CMD_W          = 2 ** CMD_SIZE_LOG2,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1,
  localparam int WD_W           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] s_cmd_data,
  input  logic             s_cmd_valid,
  output logic             s_cmd_ready,
  output logic [CMD_W-1:0] cmd,
  output logic             enable,
  input  logic             valid,
  input  logic             flush,
  input  logic             clear_err,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt,
  output logic [LVL_W-1:0] fifo_level
);

  typedef pp_constants::pp_seq_state_t state_t;

  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_n;
  logic [CMD_W-1:0] cmd_n;
  logic [CMD_W-1:0] head;
  logic             enable_n;
  logic             err_n;
  logic [CNT_W-1:0] done_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             timeout;

  assign s_cmd_ready = !fifo_full && !reset;
  assign busy        = (state != pp_constants::IDLE) || (fifo_level != '0);
  assign timeout     = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);

  pp_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (s_cmd_data),
    .wr_en   (s_cmd_valid && s_cmd_ready),
    .rd_en   (pop),
    .flush   (flush),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= pp_constants::IDLE;
      cmd      <= '0;
      enable   <= 1'b0;
      err      <= 1'b0;
      done_cnt <= '0;
      wd       <= '0;
    end else begin
      state    <= state_n;
      cmd      <= cmd_n;
      enable   <= enable_n;
      err      <= err_n;
      done_cnt <= done_n;
      wd       <= wd_n;
    end
  end

  // A completion that lands on the last watchdog cycle still counts as a normal finish.
  always_comb begin
    state_n  = state;
    cmd_n    = cmd;
    enable_n = enable;
    err_n    = err;
    done_n   = done_cnt;
    wd_n     = wd;
    pop      = 1'b0;
    unique case (state)
      pp_constants::IDLE: begin
        if (!fifo_empty && !flush) begin
          pop      = 1'b1;
          cmd_n    = head;
          enable_n = 1'b1;
          wd_n     = '0;
          state_n  = pp_constants::EXEC;
        end
      end
      pp_constants::EXEC: begin
        if (valid) begin
          enable_n = 1'b0;
          done_n   = done_cnt + 1'b1;
          state_n  = pp_constants::IDLE;
        end else begin
          wd_n = wd + 1'b1;
          if (timeout) begin
            enable_n = 1'b0;
            err_n    = 1'b1;
            state_n  = pp_constants::ERROR;
          end
        end
      end
      pp_constants::ERROR: begin
        if (clear_err) begin
          err_n   = 1'b0;
          state_n = pp_constants::IDLE;
        end
      end
      default: state_n = pp_constants::IDLE;
    endcase
  end

endmodule

// File: tb/tb_pp_cmd_sequencer.sv
// tb/tb_pp_cmd_sequencer.sv - randomized self-checking bench for pp_cmd_sequencer
module tb_pp_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_cmd_data;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [31:0] cmd;
  logic        enable;
  logic        valid;
  logic        flush;
  logic        clear_err;
  logic        busy;
  logic        err;
  logic [15:0] done_cnt;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  // Reference model: words waiting at the host, words queued, and the command in flight.
  logic [31:0] host_q[$];
  logic [31:0] m_q[$];
  logic [31:0] m_cur;
  logic        m_en;
  logic        m_err;
  int          m_mode;
  int          m_age;
  logic [15:0] m_done;

  pp_cmd_sequencer #(
    .CMD_SIZE_LOG2  (5),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_cmd_data  (s_cmd_data),
    .s_cmd_valid (s_cmd_valid),
    .s_cmd_ready (s_cmd_ready),
    .cmd         (cmd),
    .enable      (enable),
    .valid       (valid),
    .flush       (flush),
    .clear_err   (clear_err),
    .busy        (busy),
    .err         (err),
    .done_cnt    (done_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic model_clear;
    host_q.delete();
    m_q.delete();
    m_cur  = '0;
    m_en   = 1'b0;
    m_err  = 1'b0;
    m_mode = 0;
    m_age  = 0;
    m_done = '0;
  endtask

  // One clock: offer the next host word, take the edge, then advance the model (mode 0 idle, 1 exec, 2 error).
  task automatic tick;
    logic        push;
    logic [31:0] w;
    push = 1'b0;
    w    = '0;
    if (host_q.size() > 0) begin
      s_cmd_valid = 1'b1;
      s_cmd_data  = host_q[0];
      w           = host_q[0];
      push        = (host_q.size() > 0) && (m_q.size() < DEPTH);
    end else begin
      s_cmd_valid = 1'b0;
      s_cmd_data  = $urandom;
    end
    @(posedge clk);
    #1;
    case (m_mode)
      0: if (m_q.size() > 0 && !flush) begin
        m_cur  = m_q.pop_front();
        m_en   = 1'b1;
        m_age  = 0;
        m_mode = 1;
      end
      1: if (valid) begin
        m_en   = 1'b0;
        m_done = m_done + 16'd1;
        m_mode = 0;
      end else if (m_age == TMO - 1) begin
        m_en   = 1'b0;
        m_err  = 1'b1;
        m_mode = 2;
      end else begin
        m_age++;
      end
      default: if (clear_err) begin
        m_err  = 1'b0;
        m_mode = 0;
      end
    endcase
    if (push) void'(host_q.pop_front());
    if (flush) m_q.delete();
    else if (push) m_q.push_back(w);
    s_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; s_cmd_valid = 1'b0; s_cmd_data = '0; valid = 1'b0; flush = 1'b0; clear_err = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (cmd !== 32'h0)       begin bad++; $display("FAIL reset_cmd got=%0h want=0", cmd); end
    total++; if (enable !== 1'b0)     begin bad++; $display("FAIL reset_enable got=%0b want=0", enable); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    total++; if (done_cnt !== 16'h0)  begin bad++; $display("FAIL reset_done got=%0d want=0", done_cnt); end
    total++; if (fifo_level !== 3'h0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (s_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", s_cmd_ready); end
    reset = 1'b0;
    #1;
    total++; if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b want=1", s_cmd_ready); end
  endtask

  task automatic test_single;
    logic [31:0] w;
    host_q.push_back(32'hA5A5_0001);
    tick();
    total++; if (enable !== 1'b0)     begin bad++; $display("FAIL single_enable_early got=%0b want=0", enable); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", fifo_level); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL single_busy got=%0b want=1", busy); end
    tick();
    total++; if (enable !== 1'b1)           begin bad++; $display("FAIL single_enable got=%0b want=1", enable); end
    total++; if (cmd !== 32'hA5A5_0001)     begin bad++; $display("FAIL single_cmd got=%0h want=a5a50001", cmd); end
    repeat (4) tick();
    total++; if (enable !== 1'b1)           begin bad++; $display("FAIL single_hold got=%0b want=1", enable); end
    valid = 1'b1; tick(); valid = 1'b0;
    total++; if (enable !== 1'b0)     begin bad++; $display("FAIL single_done_enable got=%0b want=0", enable); end
    total++; if (done_cnt !== 16'd1)  begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL single_done_busy got=%0b want=0", busy); end
    total++; if (cmd !== 32'hA5A5_0001) begin bad++; $display("FAIL single_cmd_hold got=%0h want=a5a50001", cmd); end
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      host_q.push_back(w);
      tick(); tick();
      total++; if (enable !== 1'b1 || cmd !== w) begin bad++; $display("FAIL single_rand_issue en=%0b cmd=%0h want cmd=%0h", enable, cmd, w); end
      repeat ($urandom_range(0, 5)) tick();
      valid = 1'b1; tick(); valid = 1'b0;
      total++; if (enable !== 1'b0 || done_cnt !== m_done) begin bad++; $display("FAIL single_rand_done en=%0b done=%0d want=%0d", enable, done_cnt, m_done); end
    end
  endtask

  task automatic test_fill;
    logic [31:0] words[6];
    test_reset();
    for (int k = 0; k < 6; k++) begin
      words[k] = $urandom;
      host_q.push_back(words[k]);
    end
    repeat (5) tick();
    total++; if (s_cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b want=0", s_cmd_ready); end
    total++; if (fifo_level !== 3'd4)  begin bad++; $display("FAIL fill_level got=%0d want=4", fifo_level); end
    total++; if (enable !== 1'b1 || cmd !== words[0]) begin bad++; $display("FAIL fill_first en=%0b cmd=%0h want=%0h", enable, cmd, words[0]); end
    for (int k = 0; k < 6; k++) begin
      total++; if (enable !== 1'b1 || cmd !== words[k]) begin bad++; $display("FAIL fill_order k=%0d en=%0b cmd=%0h want=%0h", k, enable, cmd, words[k]); end
      total++; if (fifo_level !== 3'(m_q.size())) begin bad++; $display("FAIL fill_level_k k=%0d got=%0d want=%0d", k, fifo_level, m_q.size()); end
      valid = 1'b1; tick(); valid = 1'b0;
      total++; if (enable !== 1'b0) begin bad++; $display("FAIL fill_gap k=%0d got=%0b want=0", k, enable); end
      tick();
    end
    total++; if (done_cnt !== 16'd6) begin bad++; $display("FAIL fill_done got=%0d want=6", done_cnt); end
    total++; if (busy !== 1'b0 || enable !== 1'b0) begin bad++; $display("FAIL fill_idle busy=%0b en=%0b want 0 0", busy, enable); end
  endtask

  task automatic test_watchdog;
    logic [31:0] words[4];
    test_reset();
    for (int k = 0; k < 4; k++) words[k] = $urandom;
    for (int k = 0; k < 3; k++) host_q.push_back(words[k]);
    tick(); tick();
    total++; if (enable !== 1'b1 || cmd !== words[0]) begin bad++; $display("FAIL wd_issue en=%0b cmd=%0h want=%0h", enable, cmd, words[0]); end
    for (int i = 1; i <= TMO; i++) begin
      tick();
      total++; if (enable !== (i < TMO) || err !== (i == TMO)) begin bad++; $display("FAIL wd_cycle i=%0d en=%0b err=%0b want en=%0b err=%0b", i, enable, err, (i < TMO), (i == TMO)); end
    end
    total++; if (fifo_level !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL wd_queued level=%0d busy=%0b want 2 1", fifo_level, busy); end
    valid = 1'b1; tick(); valid = 1'b0;
    total++; if (done_cnt !== 16'd0 || err !== 1'b1 || enable !== 1'b0) begin bad++; $display("FAIL wd_valid_ignored done=%0d err=%0b en=%0b want 0 1 0", done_cnt, err, enable); end
    host_q.push_back(words[3]);
    repeat (3) tick();
    total++; if (fifo_level !== 3'd3 || enable !== 1'b0) begin bad++; $display("FAIL wd_error_push level=%0d en=%0b want 3 0", fifo_level, enable); end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    total++; if (err !== 1'b0 || enable !== 1'b0) begin bad++; $display("FAIL wd_clear err=%0b en=%0b want 0 0", err, enable); end
    tick();
    total++; if (enable !== 1'b1 || cmd !== words[1]) begin bad++; $display("FAIL wd_resume en=%0b cmd=%0h want=%0h", enable, cmd, words[1]); end
  endtask

  task automatic test_tie;
    for (int i = 1; i < TMO; i++) begin
      tick();
      total++; if (enable !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL tie_wait i=%0d en=%0b err=%0b want 1 0", i, enable, err); end
    end
    valid = 1'b1; tick(); valid = 1'b0;
    total++; if (enable !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL tie_complete en=%0b err=%0b want 0 0", enable, err); end
    total++; if (done_cnt !== 16'd1) begin bad++; $display("FAIL tie_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_flush;
    logic [31:0] words[5];
    test_reset();
    for (int k = 0; k < 5; k++) words[k] = $urandom;
    for (int k = 0; k < 4; k++) host_q.push_back(words[k]);
    repeat (4) tick();
    total++; if (fifo_level !== 3'd3 || enable !== 1'b1) begin bad++; $display("FAIL flush_pre level=%0d en=%0b want 3 1", fifo_level, enable); end
    host_q.push_back(words[4]);
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", fifo_level); end
    total++; if (enable !== 1'b1 || cmd !== words[0] || busy !== 1'b1) begin bad++; $display("FAIL flush_exec en=%0b cmd=%0h busy=%0b want 1 %0h 1", enable, cmd, busy, words[0]); end
    repeat (3) tick();
    total++; if (enable !== 1'b1 || fifo_level !== 3'd0) begin bad++; $display("FAIL flush_hold en=%0b level=%0d want 1 0", enable, fifo_level); end
    valid = 1'b1; tick(); valid = 1'b0;
    repeat (3) tick();
    total++; if (enable !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd1) begin bad++; $display("FAIL flush_after en=%0b busy=%0b done=%0d want 0 0 1", enable, busy, done_cnt); end
    host_q.push_back($urandom);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (enable !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL flush_idle_issue en=%0b level=%0d want 0 0", enable, fifo_level); end
  endtask

  task automatic test_async_reset;
    test_reset();
    repeat (3) host_q.push_back($urandom);
    tick(); tick();
    valid = 1'b1; tick(); valid = 1'b0;
    tick();
    total++; if (enable !== 1'b1 || done_cnt !== 16'd1) begin bad++; $display("FAIL areset_pre en=%0b done=%0d want 1 1", enable, done_cnt); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (enable !== 1'b0 || cmd !== 32'h0) begin bad++; $display("FAIL areset_out en=%0b cmd=%0h want 0 0", enable, cmd); end
    total++; if (fifo_level !== 3'd0 || s_cmd_ready !== 1'b0) begin bad++; $display("FAIL areset_fifo level=%0d ready=%0b want 0 0", fifo_level, s_cmd_ready); end
    total++; if (done_cnt !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL areset_state done=%0d busy=%0b want 0 0", done_cnt, busy); end
    model_clear();
    reset = 1'b0;
    #1;
    tick();
    total++; if (s_cmd_ready !== 1'b1 || done_cnt !== 16'd0 || enable !== 1'b0) begin bad++; $display("FAIL areset_release ready=%0b done=%0d en=%0b want 1 0 0", s_cmd_ready, done_cnt, enable); end
  endtask

  task automatic test_random;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && host_q.size() < 3) host_q.push_back($urandom);
      valid     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      clear_err = ($urandom_range(0, 4) == 0);
      tick();
      total++; if (enable !== m_en)  begin bad++; $display("FAIL rand_enable c=%0d got=%0b want=%0b", c, enable, m_en); end
      total++; if (cmd !== m_cur)    begin bad++; $display("FAIL rand_cmd c=%0d got=%0h want=%0h", c, cmd, m_cur); end
      total++; if (err !== m_err)    begin bad++; $display("FAIL rand_err c=%0d got=%0b want=%0b", c, err, m_err); end
      total++; if (done_cnt !== m_done) begin bad++; $display("FAIL rand_done c=%0d got=%0d want=%0d", c, done_cnt, m_done); end
      total++; if (fifo_level !== 3'(m_q.size())) begin bad++; $display("FAIL rand_level c=%0d got=%0d want=%0d", c, fifo_level, m_q.size()); end
      total++; if (s_cmd_ready !== (m_q.size() < DEPTH)) begin bad++; $display("FAIL rand_ready c=%0d got=%0b want=%0b", c, s_cmd_ready, (m_q.size() < DEPTH)); end
      total++; if (busy !== (m_mode != 0 || m_q.size() != 0)) begin bad++; $display("FAIL rand_busy c=%0d got=%0b want=%0b", c, busy, (m_mode != 0 || m_q.size() != 0)); end
    end
    valid = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_watchdog();
    test_tie();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
